// File: rtl/mc_main_fsm_pkg.sv
// Shared types for the multicycle main controller: state encoding, datapath
// select codes and the control word produced by the state decoder.
package mc_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } statetype_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_RN  = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ir_write/next_pc/mem_w are raw requests; the top qualifies them with MemReady.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_main_fsm_if.sv
// Instruction-field, memory-ready and control-strobe bundle between the
// datapath (master) and the main sequencing FSM (slave).
interface mc_main_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       InstrDone;
    logic       Illegal;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
        input  NextPC, RegW, MemW, Branch, InstrDone, Illegal
    );

    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
        output NextPC, RegW, MemW, Branch, InstrDone, Illegal
    );

endinterface

// File: rtl/mc_main_fsm_state_decode.sv
// Pure lookup from the registered FSM state to the datapath control word.
module mc_main_fsm_state_decode
    import mc_main_fsm_pkg::*;
(
    input  statetype_t state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_RM;
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RN;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
            end
            S_UNKNOWN: begin
                ctrl.illegal    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main sequencing FSM of the multicycle ARM core: state register, next-state
// logic, memory-ready qualification of strobes and the instruction-done pulse.
module mc_main_fsm
    import mc_main_fsm_pkg::*;
#(
    parameter bit TRAP_HOLD = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mc_main_fsm_if.slave  bus
);

    statetype_t state;
    ctrl_t      ctrl;
    logic       done;
    logic       unused_funct;

    mc_main_fsm_state_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Shift/ALU-function bits of Funct are consumed by aludec, not here.
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (bus.MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.Op)
                        OP_DP:   state <= bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_MEM:  state <= S_MEMADR;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR:   state <= bus.Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:    if (bus.MemReady) state <= S_MEMWB;
                S_MEMWR:    if (bus.MemReady) state <= S_FETCH;
                S_EXECUTER,
                S_EXECUTEI: state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH:   state <= S_FETCH;
                S_UNKNOWN:  if (!TRAP_HOLD) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Last cycle of an instruction is the one whose successor is FETCH; the trap never completes.
    assign done = (state inside {S_MEMWB, S_ALUWB, S_BRANCH})
                | ((state == S_MEMWR) & bus.MemReady);

    assign bus.IRWrite   = ~reset & ctrl.ir_write & bus.MemReady;
    assign bus.NextPC    = ~reset & ctrl.next_pc & bus.MemReady;
    assign bus.MemW      = ~reset & ctrl.mem_w & bus.MemReady;
    assign bus.RegW      = ~reset & ctrl.reg_w;
    assign bus.Branch    = ~reset & ctrl.branch;
    assign bus.InstrDone = ~reset & done;
    assign bus.Illegal   = ~reset & ctrl.illegal;
    assign bus.AdrSrc    = ~reset & ctrl.adr_src;
    assign bus.ALUOp     = ~reset & ctrl.alu_op;
    assign bus.ALUSrcA   = reset ? 2'b00 : ctrl.alu_src_a;
    assign bus.ALUSrcB   = reset ? 2'b00 : ctrl.alu_src_b;
    assign bus.ResultSrc = reset ? 2'b00 : ctrl.result_src;

endmodule
